// File: rtl/hazard_unit.sv
// Decode-stage hazard unit: tracks in-flight destinations, picks forwarding sources, raises load-use stalls.
// Optional macro HAZARD_BRANCH_FWD_EN: branches forward like other instructions instead of stalling on entry 1.
module hazard_unit #(
    parameter int REG_AW = 5,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    input  logic              use_rs1,
    input  logic              use_rs2,
    input  logic [REG_AW-1:0] rd,
    input  logic              wr_rd,
    input  logic              is_load,
    input  logic              is_branch,
    input  logic              flush,
    output logic              stall,
    output logic [2:0]        fwd_a,
    output logic [2:0]        fwd_b,
    output logic [15:0]       hz_cnt
);

    logic [DEPTH-1:0]  r_valid;
    logic [DEPTH-1:0]  r_load;
    logic [REG_AW-1:0] r_rd [DEPTH];
    logic [15:0]       r_hz_cnt;

    logic [DEPTH-1:0]  w_match_a;
    logic [DEPTH-1:0]  w_match_b;
    logic [2:0]        w_fwd_a;
    logic [2:0]        w_fwd_b;
    logic              w_src_a;
    logic              w_src_b;
    logic              w_load_use;
    logic              w_branch_stall;
    logic              w_stall;
    logic              w_enter;

    assign w_src_a = use_rs1 && (rs1 != '0);
    assign w_src_b = use_rs2 && (rs2 != '0);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_match_a = '0;
        w_match_b = '0;
        w_fwd_a   = '0;
        w_fwd_b   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_match_a[k] = w_src_a && r_valid[k] && (r_rd[k] == rs1);
            w_match_b[k] = w_src_b && r_valid[k] && (r_rd[k] == rs2);
        end
        // Walk from the oldest stage down so the nearest match is written last and wins.
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (w_match_a[k]) w_fwd_a = 3'(k + 1);
            if (w_match_b[k]) w_fwd_b = 3'(k + 1);
        end
        if (!id_valid) begin
            w_fwd_a = '0;
            w_fwd_b = '0;
        end
    end

    assign w_load_use = id_valid && r_load[0] && (w_match_a[0] || w_match_b[0]);

`ifdef HAZARD_BRANCH_FWD_EN
    assign w_branch_stall = 1'b0;
`else
    assign w_branch_stall = id_valid && is_branch && (w_match_a[0] || w_match_b[0]);
`endif

    assign w_stall = !flush && (w_load_use || w_branch_stall);
    assign w_enter = id_valid && wr_rd && (rd != '0) && !w_stall && !flush;

    // History shifts every cycle; a stalled or flushed decode slot enters as a bubble.
    // NOTE: sequential state uses non-blocking assignments so all stages shift from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= '0;
            r_hz_cnt <= '0;
        end else begin
            r_valid[0] <= w_enter;
            for (int k = 1; k < DEPTH; k++) r_valid[k] <= r_valid[k-1];
            if (w_stall && (r_hz_cnt != 16'hFFFF)) r_hz_cnt <= r_hz_cnt + 16'd1;
        end
    end

    // NOTE: payload fields are qualified by r_valid, so they are deliberately left out of reset.
    always_ff @(posedge clk) begin
        r_rd[0]   <= rd;
        r_load[0] <= is_load;
        for (int k = 1; k < DEPTH; k++) begin
            r_rd[k]   <= r_rd[k-1];
            r_load[k] <= r_load[k-1];
        end
    end

    assign stall  = w_stall;
    assign fwd_a  = w_fwd_a;
    assign fwd_b  = w_fwd_b;
    assign hz_cnt = r_hz_cnt;

endmodule
